// File: rtl/x_delay_ring.sv
// x_delay_ring: programmable multi-bit delay line on a circular buffer.
// Delays a MXWID-bit word by 0..(1<<MXDLY)-1 clocks. The delay is chosen at run time.
// Samples not yet written since reset or clear are flagged invalid and masked to 0.
// Optional feature macro: X_DELAY_RING_OREG_EN registers q/qvld, which adds one clock of latency.
module x_delay_ring #(
  parameter int unsigned MXDLY = 6,
  parameter int unsigned MXWID = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [MXWID-1:0] d,
  input  logic [MXDLY-1:0] delay,
  output logic [MXWID-1:0] q,
  output logic             qvld
);

  localparam int unsigned MXSR = 1 << MXDLY;
  localparam logic [MXDLY-1:0] FILL_MAX = MXDLY'(MXSR - 1);
  localparam logic [MXDLY-1:0] PTR_ONE  = MXDLY'(1);

  logic [MXDLY-1:0] wptr_q, wptr_d;
  logic [MXDLY-1:0] fill_q, fill_d;
  logic [MXDLY-1:0] raddr;
  logic [MXWID-1:0] ram_q [MXSR];
  logic [MXWID-1:0] sel_word;
  logic             vld_c;
  logic [MXWID-1:0] q_c;

  // Ring storage: not reset, and never visible while the output is invalid
  always_ff @(posedge clock) begin
    if (reset_n) begin
      ram_q[wptr_q] <= d;
    end
  end

  // Write pointer and fill-history registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      fill_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      fill_q <= fill_d;
    end
  end

  // Next-state: pointer wraps naturally, fill saturates and restarts on clear
  always_comb begin
    wptr_d = wptr_q + PTR_ONE;
    fill_d = fill_q;
    if (clear) begin
      fill_d = '0;
    end else if (fill_q != FILL_MAX) begin
      fill_d = fill_q + PTR_ONE;
    end
  end

  // Read select: delay 0 bypasses the ring. Validity is gated by reset so outputs drop asynchronously.
  always_comb begin
    raddr    = wptr_q - delay;
    sel_word = (delay == '0) ? d : ram_q[raddr];
    vld_c    = reset_n && !clear && ((delay == '0) || (fill_q >= delay));
    q_c      = vld_c ? sel_word : '0;
  end

`ifdef X_DELAY_RING_OREG_EN
  logic [MXWID-1:0] q_q;
  logic             qvld_q;

  // Output register stage, which adds one clock to every path
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_q    <= '0;
      qvld_q <= 1'b0;
    end else begin
      q_q    <= q_c;
      qvld_q <= vld_c;
    end
  end

  assign q    = q_q;
  assign qvld = qvld_q;
`else
  assign q    = q_c;
  assign qvld = vld_c;
`endif

endmodule
